// File: rtl/counter_read_ctrl.sv
// Sweeps the channels selected by a 4-bit mask of a four-channel counter block,
// one read per channel, and presents each captured value with its channel number.
//
// state  | meaning
// IDLE   | waiting for start; no request to the counter block
// READ   | request asserted for channel idx; capture when valid_in and idle
// DONE   | one-cycle completion pulse, then back to IDLE
module counter_read_ctrl #(
    parameter int CBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mask,
    input  logic             idle,
    input  logic [CBITS-1:0] counter_in,
    input  logic             valid_in,
    output logic [1:0]       idx,
    output logic             req,
    output logic [CBITS-1:0] data_out,
    output logic [1:0]       data_idx,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_mask_q;
    logic [1:0]       r_idx;
    logic [CBITS-1:0] r_data_out;
    logic [1:0]       r_data_idx;
    logic             r_data_valid;

    logic             w_req;
    logic             w_busy;
    logic             w_done;
    logic             w_load;
    logic             w_cap;
    logic [3:0]       w_mask_rem;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = i[1:0];
        end
        return r;
    endfunction

    // Channels still pending once the current one has been captured.
    assign w_mask_rem = r_mask_q & ~(4'b0001 << r_idx);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (mask != 4'd0) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_READ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                // A read only completes while the system is idle and the block qualifies it.
                if (valid_in && idle) begin
                    w_cap = 1'b1;
                    if (w_mask_rem == 4'd0) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask_q     <= 4'd0;
            r_idx        <= 2'd0;
            r_data_out   <= '0;
            r_data_idx   <= 2'd0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_load) begin
                r_mask_q <= mask;
                r_idx    <= f_lowest(mask);
            end
            if (w_cap) begin
                r_data_out   <= counter_in;
                r_data_idx   <= r_idx;
                r_data_valid <= 1'b1;
                r_mask_q     <= w_mask_rem;
                if (w_mask_rem != 4'd0) r_idx <= f_lowest(w_mask_rem);
            end
        end
    end

    assign idx        = r_idx;
    assign req        = w_req;
    assign busy       = w_busy;
    assign done       = w_done;
    assign data_out   = r_data_out;
    assign data_idx   = r_data_idx;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_counter_read_ctrl.sv
// Bench for counter_read_ctrl: fixed vector table, directed multi-cycle sequences,
// then random traffic checked against a queue-based sweep model.
module tb_counter_read_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, idle, valid_in;
    logic [3:0] mask;
    logic [4:0] counter_in;
    logic [1:0] idx, data_idx;
    logic       req, data_valid, busy, done;
    logic [4:0] data_out;
    logic [4:0] cnt_arr [4];

    int tests = 0;
    int fails = 0;

    counter_read_ctrl #(.CBITS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mask(mask), .idle(idle),
        .counter_in(counter_in), .valid_in(valid_in), .idx(idx), .req(req),
        .data_out(data_out), .data_idx(data_idx), .data_valid(data_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Counter block: returns the value of whichever channel is selected.
    always_comb counter_in = cnt_arr[idx];

    // Reference model: list of channels still to read, plus registered outputs.
    int pend[$];
    bit m_done;
    bit m_dv;
    int m_dout, m_didx;

    task automatic model_adv();
        if (reset) begin
            pend.delete();
            m_done = 0; m_dv = 0; m_dout = 0; m_didx = 0;
            return;
        end
        m_dv = 0;
        if (m_done) begin
            m_done = 0;
        end else if (pend.size() > 0) begin
            if (valid_in && idle) begin
                m_dout = int'(cnt_arr[pend[0]]);
                m_didx = pend[0];
                m_dv   = 1;
                void'(pend.pop_front());
                if (pend.size() == 0) m_done = 1;
            end
        end else if (start) begin
            if (mask == 4'd0) m_done = 1;
            else for (int c = 0; c < 4; c++) if (mask[c]) pend.push_back(c);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".req"},        int'(req),        int'(pend.size() > 0));
        chk({tag, ".busy"},       int'(busy),       int'(pend.size() > 0 || m_done));
        chk({tag, ".done"},       int'(done),       int'(m_done));
        chk({tag, ".data_valid"}, int'(data_valid), int'(m_dv));
        chk({tag, ".data_idx"},   int'(data_idx),   m_didx);
        chk({tag, ".data_out"},   int'(data_out),   m_dout);
        if (pend.size() > 0) chk({tag, ".idx"}, int'(idx), pend[0]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_adv();
        @(negedge clk);
        cmp_model(tag);
    endtask

    typedef struct {
        logic       rst, st;
        logic [3:0] msk;
        logic       e_req, e_busy, e_done, e_dv;
        logic [1:0] e_didx, e_idx;
        logic [4:0] e_dout;
    } vec_t;

    function automatic vec_t mk(logic rst, logic st, logic [3:0] msk, logic rq, logic bs,
                                logic dn, logic dv, logic [1:0] di, logic [4:0] dd, logic [1:0] ix);
        vec_t v;
        v.rst = rst; v.st = st; v.msk = msk; v.e_req = rq; v.e_busy = bs; v.e_done = dn;
        v.e_dv = dv; v.e_didx = di; v.e_dout = dd; v.e_idx = ix;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done, n_dv, cyc;
        bit seen;

        reset = 1; start = 0; mask = 0; idle = 1; valid_in = 1;
        cnt_arr[0] = 5'd3; cnt_arr[1] = 5'd7; cnt_arr[2] = 5'd11; cnt_arr[3] = 5'd31;
        @(negedge clk); @(negedge clk);

        //            rst st  msk    req bsy dn dv didx dout idx
        vecs[0]  = mk(1, 1, 4'hF,   0, 0, 0, 0, 0, 0,  0);
        vecs[1]  = mk(0, 1, 4'hF,   1, 1, 0, 0, 0, 0,  0);
        vecs[2]  = mk(0, 0, 4'hF,   1, 1, 0, 1, 0, 3,  1);
        vecs[3]  = mk(0, 0, 4'hF,   1, 1, 0, 1, 1, 7,  2);
        vecs[4]  = mk(0, 0, 4'hF,   1, 1, 0, 1, 2, 11, 3);
        vecs[5]  = mk(0, 0, 4'hF,   0, 1, 1, 1, 3, 31, 0);
        vecs[6]  = mk(0, 0, 4'hF,   0, 0, 0, 0, 3, 31, 0);
        vecs[7]  = mk(0, 1, 4'hA,   1, 1, 0, 0, 3, 31, 1);
        vecs[8]  = mk(0, 0, 4'hA,   1, 1, 0, 1, 1, 7,  3);
        vecs[9]  = mk(0, 0, 4'hA,   0, 1, 1, 1, 3, 31, 0);
        vecs[10] = mk(0, 0, 4'hA,   0, 0, 0, 0, 3, 31, 0);
        vecs[11] = mk(0, 1, 4'h0,   0, 1, 1, 0, 3, 31, 0);
        vecs[12] = mk(0, 0, 4'h0,   0, 0, 0, 0, 3, 31, 0);
        vecs[13] = mk(1, 0, 4'h0,   0, 0, 0, 0, 0, 0,  0);

        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst; start = vecs[i].st; mask = vecs[i].msk;
            @(posedge clk);
            model_adv();
            @(negedge clk);
            chk($sformatf("vec%0d.req", i),        int'(req),        int'(vecs[i].e_req));
            chk($sformatf("vec%0d.busy", i),       int'(busy),       int'(vecs[i].e_busy));
            chk($sformatf("vec%0d.done", i),       int'(done),       int'(vecs[i].e_done));
            chk($sformatf("vec%0d.data_valid", i), int'(data_valid), int'(vecs[i].e_dv));
            chk($sformatf("vec%0d.data_idx", i),   int'(data_idx),   int'(vecs[i].e_didx));
            chk($sformatf("vec%0d.data_out", i),   int'(data_out),   int'(vecs[i].e_dout));
            if (vecs[i].e_req || vecs[i].rst)
                chk($sformatf("vec%0d.idx", i), int'(idx), int'(vecs[i].e_idx));
        end
        reset = 0; start = 0;

        // Stall: idle low for three cycles while channel 2 is requested.
        start = 1; mask = 4'hF; idle = 1; valid_in = 1;
        step("stall");
        start = 0; mask = 4'h0;
        step("stall");
        step("stall");
        chk("stall.idx_before", int'(idx), 2);
        idle = 0; valid_in = 0;
        for (int k = 0; k < 3; k++) begin
            step("stall");
            chk("stall.hold_idx", int'(idx), 2);
            chk("stall.hold_req", int'(req), 1);
            chk("stall.no_dv", int'(data_valid), 0);
        end
        idle = 1; valid_in = 1;
        step("stall");
        chk("stall.resume_didx", int'(data_idx), 2);
        chk("stall.resume_dout", int'(data_out), 11);
        step("stall");
        chk("stall.done_at_8", int'(done), 1);
        step("stall");

        // Reset while reading channel 1, then a fresh sweep.
        start = 1; mask = 4'hF;
        step("rst_mid");
        start = 0;
        step("rst_mid");
        reset = 1;
        step("rst_mid");
        chk("rst_mid.req", int'(req), 0);
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.done", int'(done), 0);
        chk("rst_mid.dv", int'(data_valid), 0);
        chk("rst_mid.dout", int'(data_out), 0);
        chk("rst_mid.didx", int'(data_idx), 0);
        chk("rst_mid.idx", int'(idx), 0);
        reset = 0;
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            step("rst_mid");
            n_done += int'(done);
        end
        chk("rst_mid.no_done", n_done, 0);
        start = 1; mask = 4'hF;
        n_dv = 0; seen = 0; cyc = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step("rst_new");
            start = 0;
            cyc++;
            n_dv += int'(data_valid);
            if (done) seen = 1;
        end
        chk("rst_new.done_seen", int'(seen), 1);
        chk("rst_new.done_cycle", cyc, 5);
        chk("rst_new.dv_count", n_dv, 4);
        step("rst_new");

        // Start held through READ and DONE, mask changed mid-sweep.
        start = 1; mask = 4'h5;
        n_done = 0; n_dv = 0;
        for (int k = 0; k < 4; k++) begin
            step("restart");
            mask = 4'hF;
            n_done += int'(done);
            n_dv += int'(data_valid);
        end
        start = 0;
        for (int k = 0; k < 6; k++) begin
            step("restart");
            n_done += int'(done);
            n_dv += int'(data_valid);
        end
        chk("restart.one_done", n_done, 1);
        chk("restart.dv_count", n_dv, 2);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(99) == 0);
            start    = ($urandom_range(3) == 0);
            mask     = 4'($urandom);
            idle     = ($urandom_range(4) != 0);
            valid_in = idle && ($urandom_range(3) != 0);
            for (int c = 0; c < 4; c++) cnt_arr[c] = 5'($urandom);
            step("rnd");
        end
        reset = 0; start = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_read_ctrl.md
COUNTER_READ_CTRL -- requirements
Module: counter_read_ctrl

Interface
REQ-001 Parameter: CBITS, default 5, width of counter values read from the four-channel counter block.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request one readout sweep; sampled only in IDLE.
REQ-005 Port: mask  input  4  channels to read (bit n = channel n); sampled with start.
REQ-006 Port: idle  input  1  system-idle flag; counter reads allowed only while high.
REQ-007 Port: counter_in  input  CBITS  value returned by the counter block.
REQ-008 Port: valid_in  input  1  counter block qualifier for counter_in.
REQ-009 Port: idx  output  2  channel select driven to the counter block.
REQ-010 Port: req  output  1  read request driven to the counter block.
REQ-011 Port: data_out  output  CBITS  captured counter value.
REQ-012 Port: data_idx  output  2  channel of data_out.
REQ-013 Port: data_valid  output  1  one-cycle qualifier for data_out/data_idx.
REQ-014 Port: busy  output  1  high while a sweep is in progress.
REQ-015 Port: done  output  1  one-cycle pulse at sweep completion.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, READ, DONE.
REQ-017 IDLE: req=0, busy=0, done=0; start=1 and mask!=0 -> latch mask into mask_q, idx <= lowest set bit of mask, go READ.
REQ-018 IDLE: start=1 and mask=0 -> go DONE directly; no req issued, no data_valid.
REQ-019 READ: req=1, busy=1; req SHALL be decoded from state, idx SHALL be registered.
REQ-020 READ with valid_in=1: data_out<=counter_in, data_idx<=idx, data_valid<=1 (visible next cycle); clear mask_q[idx].
REQ-021 After capture: if no mask_q bits remain -> DONE; else idx <= next lowest set bit, stay READ; masked channels skipped with zero extra cycles.
REQ-022 READ with valid_in=0 (idle low): hold idx and mask_q, keep req=1, no capture; resume on first cycle valid_in=1.
REQ-023 valid_in while not in READ SHALL be ignored.
REQ-024 DONE: done=1, busy=1, req=0 for exactly one cycle, then IDLE unconditionally.
REQ-025 start in READ or DONE SHALL be ignored (not queued); mask changes after sampling have no effect on the current sweep.
REQ-026 data_valid SHALL be high exactly one cycle per capture; data_out/data_idx hold last captured value otherwise.
REQ-027 Latency, idle held high, mask=4'b1111, start high in cycle 0: READ cycles 1-4 (idx 0,1,2,3); data_valid cycles 2-5 (data_idx 0-3); done cycle 5; IDLE cycle 6.
REQ-028 Sweep length SHALL equal popcount(mask) READ cycles plus stall cycles plus one DONE cycle.

Reset
REQ-029 reset=1 at posedge: state IDLE, idx=0, mask_q=0, data_out=0, data_idx=0, data_valid=0, done=0; req=0, busy=0.
REQ-030 Reset mid-sweep SHALL abort immediately: no done pulse, no further data_valid, no pending state retained.
REQ-031 reset SHALL take priority over start and valid_in in the same cycle.

Verification
REQ-032 idle=1, counters 3,7,11,31, mask=4'hF, start cycle 0 -> data_valid cycles 2-5 with (idx,data) (0,3),(1,7),(2,11),(3,31); done cycle 5.
REQ-033 mask=4'b1010, start -> reads idx 1 then idx 3 only; exactly two data_valid pulses; done 3 cycles after start.
REQ-034 mask=4'b0000, start -> done next cycle; req never high; no data_valid.
REQ-035 idle forced low 3 cycles during idx 2 read -> req stays 1, idx stays 2, no data_valid; capture of idx 2 resumes when idle returns; done delayed 3 cycles.
REQ-036 reset pulsed while busy at idx 1 -> next cycle all outputs zero, state IDLE, no done; new start then performs a full sweep correctly.
REQ-037 start re-asserted during READ and DONE -> ignored; exactly one done per accepted start.
